tape_in_conditioner: RTL and testbench

//  Converts the signed 24-bit left-channel ADC sample stream from the audio core into a clean tape level for the

---
 rtl/tape_in_conditioner.sv | 115 +++++++++++
 tb/tb_tape_in_conditioner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tape_in_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tape_in_conditioner
// Brief   : ADC sample stream -> hysteresis/glitch-filtered tape level, with
//           carrier detect and half-period measurement.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tape_in_conditioner #(
  parameter int SAMPLE_W    = 24,
  parameter int THR_HI      = 419430,
  parameter int THR_LO      = 209715,
  parameter int MIN_RUN     = 3,
  parameter int PER_W       = 20,
  parameter int SILENCE_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                tape_level,
  output logic                tape_edge,
  output logic                carrier,
  output logic [PER_W-1:0]    half_period
);

  localparam int RUN_W = (MIN_RUN > 1) ? $clog2(MIN_RUN) : 1;
  localparam logic [RUN_W-1:0]           RUN_LAST = RUN_W'(MIN_RUN - 1);
  localparam logic signed [SAMPLE_W-1:0] THR_HI_S = SAMPLE_W'(THR_HI);
  localparam logic signed [SAMPLE_W-1:0] THR_LO_S = SAMPLE_W'(THR_LO);
  localparam logic [PER_W-1:0]           PER_MAX  = '1;
  localparam logic [PER_W-1:0]           SIL_LAST = PER_W'(SILENCE_CYC - 1);

  logic                 ready_q,   ready_d;
  logic                 level_q,   level_d;
  logic                 edge_q,    edge_d;
  logic                 carrier_q, carrier_d;
  logic [PER_W-1:0]     half_q,    half_d;
  logic [PER_W-1:0]     per_q,     per_d;
  logic [RUN_W-1:0]     run_q,     run_d;

  logic                       accept;
  logic                       cand;
  logic                       qual;
  logic signed [SAMPLE_W-1:0] sample_s;

  assign sample_s = $signed(sample_data);
  assign accept   = sample_valid & ready_q;
  // Hysteresis: the threshold that matters depends on the current level.
  assign cand     = level_q ? (sample_s < THR_LO_S) : (sample_s >= THR_HI_S);
  assign qual     = accept & cand & (run_q == RUN_LAST);

  always_comb begin
    ready_d   = 1'b1;
    level_d   = level_q ^ qual;
    edge_d    = qual;
    run_d     = run_q;
    per_d     = per_q;
    half_d    = half_q;
    carrier_d = carrier_q;

    if (accept) begin
      if (!cand || qual) begin
        run_d = '0;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end

    if (qual) begin
      per_d = '0;
    end else if (per_q != PER_MAX) begin
      per_d = per_q + PER_W'(1);
    end

    // A period is only meaningful when the previous toggle was part of the same carrier.
    if (qual && carrier_q) begin
      half_d = (per_q == PER_MAX) ? PER_MAX : per_q + PER_W'(1);
    end

    if (qual) begin
      carrier_d = 1'b1;
    end else if (per_q == SIL_LAST) begin
      carrier_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      level_q   <= 1'b0;
      edge_q    <= 1'b0;
      carrier_q <= 1'b0;
      half_q    <= '0;
      per_q     <= '0;
      run_q     <= '0;
    end else begin
      ready_q   <= ready_d;
      level_q   <= level_d;
      edge_q    <= edge_d;
      carrier_q <= carrier_d;
      half_q    <= half_d;
      per_q     <= per_d;
      run_q     <= run_d;
    end
  end

  assign sample_ready = ready_q;
  assign tape_level   = level_q;
  assign tape_edge    = edge_q;
  assign carrier      = carrier_q;
  assign half_period  = half_q;

endmodule
`default_nettype wire

// File: tb/tb_tape_in_conditioner.sv
`default_nettype none
// Bench for tape_in_conditioner: two instances (MIN_RUN=3 and MIN_RUN=1) share
// one stimulus stream and are checked every cycle against a timestamp-based model.
module tb_tape_in_conditioner;

  localparam int THR_HI = 419430;
  localparam int THR_LO = 209715;
  localparam int SIL    = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] sdata = '0;
  logic        svalid = 1'b0;

  logic        rdy0, lvl0, edg0, car0;
  logic [19:0] half0;
  logic        rdy1, lvl1, edg1, car1;
  logic [11:0] half1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tape_in_conditioner #(.MIN_RUN(3), .PER_W(20), .SILENCE_CYC(SIL)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sample_data(sdata), .sample_valid(svalid),
    .sample_ready(rdy0), .tape_level(lvl0), .tape_edge(edg0), .carrier(car0),
    .half_period(half0)
  );

  tape_in_conditioner #(.MIN_RUN(1), .PER_W(12), .SILENCE_CYC(SIL)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sample_data(sdata), .sample_valid(svalid),
    .sample_ready(rdy1), .tape_level(lvl1), .tape_edge(edg1), .carrier(car1),
    .half_period(half1)
  );

  // Reference state: level, run length, time of last toggle, last measured period.
  int m_run[2];
  int m_last[2];
  int m_half[2];
  bit m_level[2];
  bit m_edge[2];
  bit m_have[2];
  bit m_ready;
  int cyc = 0;

  function automatic int minr(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic int pmax(input int k);
    return (k == 0) ? (1 << 20) - 1 : (1 << 12) - 1;
  endfunction

  function automatic bit m_carrier(input int k, input int at);
    return m_have[k] && ((at - m_last[k]) < SIL);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_half[k] = 0; m_level[k] = 0; m_edge[k] = 0; m_have[k] = 0;
      m_last[k] = 0;
    end
    m_ready = 0;
  endtask

  task automatic model_clock(input bit v, input logic [23:0] d);
    int  sv;
    bit  cand;
    bit  qual;
    cyc++;
    sv = $signed(d);
    for (int k = 0; k < 2; k++) begin
      qual = 0;
      if (v && m_ready) begin
        cand = m_level[k] ? (sv < THR_LO) : (sv >= THR_HI);
        if (cand) begin
          m_run[k]++;
          if (m_run[k] == minr(k)) begin
            qual = 1;
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_edge[k] = qual;
      if (qual) begin
        if (m_carrier(k, cyc - 1))
          m_half[k] = ((cyc - m_last[k]) > pmax(k)) ? pmax(k) : (cyc - m_last[k]);
        m_have[k]  = 1;
        m_last[k]  = cyc;
        m_level[k] = !m_level[k];
      end
    end
    m_ready = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d0.ready",   32'(rdy0),  32'(m_ready));
    chk("d0.level",   32'(lvl0),  32'(m_level[0]));
    chk("d0.edge",    32'(edg0),  32'(m_edge[0]));
    chk("d0.carrier", 32'(car0),  32'(m_carrier(0, cyc)));
    chk("d0.half",    32'(half0), 32'(m_half[0]));
    chk("d1.ready",   32'(rdy1),  32'(m_ready));
    chk("d1.level",   32'(lvl1),  32'(m_level[1]));
    chk("d1.edge",    32'(edg1),  32'(m_edge[1]));
    chk("d1.carrier", 32'(car1),  32'(m_carrier(1, cyc)));
    chk("d1.half",    32'(half1), 32'(m_half[1]));
  endtask

  // Entered at a negedge; leaves at the next negedge.
  task automatic step(input bit v, input int d);
    svalid = v;
    sdata  = 24'(d);
    @(posedge clk);
    model_clock(v, 24'(d));
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  // Asserts reset mid-cycle with stimulus still active; leaves at a negedge.
  task automatic pulse_reset();
    svalid = 1'b1;
    sdata  = 24'(500000);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  int pick;
  int val;

  initial begin
    model_reset();
    @(negedge clk);
    // Reset with live stimulus, then release: ready rises after one clock.
    pulse_reset();
    step(0, 0);
    chk("t1.ready_after_release", 32'(rdy0), 32'd1);
    chk("t1.level_after_release", 32'(lvl0), 32'd0);

    // Three strong samples rise the level, edge pulses once.
    step(1, 500000); step(1, 500000);
    chk("t2.no_toggle_after_2", 32'(lvl0), 32'd0);
    step(1, 500000);
    chk("t2.level_rise", 32'(lvl0), 32'd1);
    chk("t2.edge_rise",  32'(edg0), 32'd1);
    step(0, 0);
    chk("t2.edge_clears", 32'(edg0), 32'd0);

    // In-band samples hold a high level; three negative samples drop it.
    for (int i = 0; i < 5; i++) step(1, 300000);
    chk("t3.band_holds", 32'(lvl0), 32'd1);
    step(1, -100000); step(1, -100000); step(1, -100000);
    chk("t3.level_fall", 32'(lvl0), 32'd0);
    chk("t3.edge_fall",  32'(edg0), 32'd1);

    // A band sample breaks the run.
    step(1, 500000); step(1, 500000); step(1, 300000); step(1, 500000);
    chk("t2.broken_run", 32'(lvl0), 32'd0);
    step(1, 300000);

    // Idle gaps between accepts do not reset the run.
    step(1, 500000); idle(7); step(1, 500000); idle(7);
    chk("t4.before_third", 32'(lvl0), 32'd0);
    step(1, 500000);
    chk("t4.gap_toggle", 32'(lvl0), 32'd1);
    chk("t4.gap_edge",   32'(edg0), 32'd1);

    // Period measurement on the MIN_RUN=1 instance, accepts 1000 clk apart.
    pulse_reset();
    step(0, 0);
    for (int n = 0; n < 4; n++) begin
      step(1, (n % 2 == 0) ? 500000 : -100000);
      chk("t5.carrier_on", 32'(car1), 32'd1);
      chk("t5.half", 32'(half1), (n == 0) ? 32'd0 : 32'd1000);
      if (n != 3) idle(999);
    end
    idle(SIL - 1);
    chk("t5.carrier_still_on", 32'(car1), 32'd1);
    step(0, 0);
    chk("t5.carrier_dropped", 32'(car1), 32'd0);
    chk("t5.half_kept",       32'(half1), 32'd1000);
    idle(20);

    // Partial run discarded by reset.
    pulse_reset();
    step(0, 0);
    step(1, 500000); step(1, 500000);
    pulse_reset();
    step(1, 500000);
    chk("t6.no_toggle",  32'(lvl0), 32'd0);
    chk("t6.no_edge",    32'(edg0), 32'd0);
    step(0, 0);

    // Randomised traffic, including exact threshold boundaries.
    for (int i = 0; i < 3000; i++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        0: val = THR_HI;
        1: val = THR_HI - 1;
        2: val = THR_LO;
        3: val = THR_LO - 1;
        4: val = $urandom_range(THR_HI, 8388607);
        5: val = -$urandom_range(0, 8388608);
        6: val = $urandom_range(THR_LO, THR_HI - 1);
        default: val = int'($urandom_range(0, 16777215)) - 8388608;
      endcase
      step(($urandom_range(0, 3) != 0), val);
      if ($urandom_range(0, 99) == 0) idle($urandom_range(1, 400));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
